// File: rtl/stoplight_pkg.sv
// Shared types and phase durations for the stoplight controller.
// Durations are counted in expiry pulses from the upstream interval counter.
package stoplight_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_t;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

    localparam logic [2:0] GREEN_TICKS  = 3'd4;
    localparam logic [2:0] YELLOW_TICKS = 3'd1;
    localparam logic [2:0] ALLRED_TICKS = 3'd1;
    localparam logic [2:0] WALK_TICKS   = 3'd3;

    function automatic logic [2:0] state_ticks(input state_t s);
        logic [2:0] t;
        case (s)
            NS_GREEN, EW_GREEN:   t = GREEN_TICKS;
            NS_YELLOW, EW_YELLOW: t = YELLOW_TICKS;
            PED_WALK:             t = WALK_TICKS;
            default:              t = ALLRED_TICKS;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/stoplight_controller.sv
// Moore FSM sequencing a two-way intersection with a pedestrian walk phase.
// Time advances only on expiry pulses from an external interval counter.
module stoplight_controller
    import stoplight_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       max_count,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk,
    output logic       timer_enable,
    output logic       timer_clear
);

    state_t     state_q, state_d;
    logic [2:0] tick_q, tick_d;
    logic       ped_pending_q, ped_pending_d;

    logic       rest;
    logic       tick_pulse;
    logic       expire;
    logic       go;
    light_t     ns_l, ew_l;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= NS_GREEN;
            tick_q        <= 3'd0;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    // Rest mode: minimum green served, counter parked until demand arrives.
    assign rest       = (state_q == NS_GREEN) && (tick_q == GREEN_TICKS);
    assign tick_pulse = max_count && !rest;
    assign expire     = tick_pulse && (tick_q == state_ticks(state_q) - 3'd1);
    assign go         = ew_car || ped_pending_q;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_pulse ? tick_q + 3'd1 : tick_q;
        case (state_q)
            NS_GREEN: begin
                if (rest) begin
                    tick_d = tick_q;
                    if (go) state_d = NS_YELLOW;
                end else if (expire) begin
                    if (go) state_d = NS_YELLOW;
                end
            end
            NS_YELLOW: if (expire) state_d = ALL_RED_A;
            ALL_RED_A: if (expire) state_d = ped_pending_q ? PED_WALK : EW_GREEN;
            EW_GREEN:  if (expire) state_d = EW_YELLOW;
            EW_YELLOW: if (expire) state_d = ALL_RED_B;
            PED_WALK:  if (expire) state_d = ALL_RED_B;
            ALL_RED_B: if (expire) state_d = NS_GREEN;
            default:   state_d = NS_GREEN;
        endcase
        if (state_d != state_q) tick_d = 3'd0;
    end

    // Entry into the walk phase consumes the request, even one arriving that cycle.
    always_comb begin
        ped_pending_d = ped_pending_q || (ped_req && (state_q != PED_WALK));
        if ((state_d == PED_WALK) && (state_q != PED_WALK)) ped_pending_d = 1'b0;
    end

    always_comb begin
        ns_l = RED;
        ew_l = RED;
        case (state_q)
            NS_GREEN:  ns_l = GREEN;
            NS_YELLOW: ns_l = YELLOW;
            EW_GREEN:  ew_l = GREEN;
            EW_YELLOW: ew_l = YELLOW;
            default: begin
                ns_l = RED;
                ew_l = RED;
            end
        endcase
    end

    assign ns_light     = ns_l;
    assign ew_light     = ew_l;
    assign walk         = (state_q == PED_WALK);
    assign timer_enable = !rest;
    assign timer_clear  = rest && go;

endmodule

// File: tb/tb_stoplight_controller.sv
// Directed bench: expected lamp/timer segments are queued, then drained cycle by cycle.
// An 11-cycle interval counter model supplies max_count from timer_enable/timer_clear.
module tb_stoplight_controller;
    import stoplight_pkg::*;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       max_count;
    logic       ew_car = 1'b0;
    logic       ped_req = 1'b0;
    logic       mc_inject = 1'b0;
    logic [1:0] ns_light, ew_light;
    logic       walk, timer_enable, timer_clear;
    logic [3:0] cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      tag;
        logic [6:0] exp;
        int         len;
    } seg_t;

    seg_t q[$];

    always #5 clk = ~clk;

    stoplight_controller dut (
        .clk          (clk),
        .nrst         (nrst),
        .max_count    (max_count),
        .ew_car       (ew_car),
        .ped_req      (ped_req),
        .ns_light     (ns_light),
        .ew_light     (ew_light),
        .walk         (walk),
        .timer_enable (timer_enable),
        .timer_clear  (timer_clear)
    );

    always @(posedge clk or negedge nrst) begin
        if (!nrst)             cnt <= 4'd0;
        else if (timer_clear)  cnt <= 4'd0;
        else if (timer_enable) cnt <= (cnt == 4'd10) ? 4'd0 : cnt + 4'd1;
    end
    assign max_count = (cnt == 4'd10) || mc_inject;

    always @(negedge clk) begin
        if (nrst) begin
            logic [1:0] obs;
            obs = {(ns_light != RED) && (ew_light != RED),
                   walk && !((ns_light == RED) && (ew_light == RED))};
            tests++;
            assert (obs === 2'b00) else begin
                fails++;
                $error("FAIL lamp_exclusive: observed %b required 00 (ns=%0d ew=%0d walk=%b)",
                       obs, ns_light, ew_light, walk);
            end
        end
    end

    function automatic seg_t mk(string tag, light_t ns, light_t ew, logic w,
                                logic en, logic clr, int len);
        seg_t s;
        s.tag = tag;
        s.exp = {ns, ew, w, en, clr};
        s.len = len;
        return s;
    endfunction

    task automatic check(string tag, logic [6:0] exp);
        logic [6:0] obs;
        obs = {ns_light, ew_light, walk, timer_enable, timer_clear};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed {ns,ew,walk,en,clr}=%b required %b", tag, obs, exp);
        end
    endtask

    task automatic drain();
        seg_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            for (int i = 0; i < s.len; i++) begin
                #1;
                check($sformatf("%s[%0d]", s.tag, i), s.exp);
                @(negedge clk);
            end
        end
    endtask

    task automatic push_ew_round();
        q.push_back(mk("ns_yellow", YELLOW, RED, 1'b0, 1'b1, 1'b0, 11));
        q.push_back(mk("all_red_a", RED, RED, 1'b0, 1'b1, 1'b0, 11));
    endtask

    task automatic push_walk_tail();
        q.push_back(mk("ped_walk", RED, RED, 1'b1, 1'b1, 1'b0, 33));
        q.push_back(mk("all_red_b", RED, RED, 1'b0, 1'b1, 1'b0, 11));
        q.push_back(mk("ns_min_green", GREEN, RED, 1'b0, 1'b1, 1'b0, 44));
    endtask

    initial begin
        // Reset hold, then idle: minimum green followed by rest
        @(negedge clk);
        q.push_back(mk("in_reset", GREEN, RED, 1'b0, 1'b1, 1'b0, 2));
        drain();
        nrst = 1'b1;
        q.push_back(mk("idle_min_green", GREEN, RED, 1'b0, 1'b1, 1'b0, 44));
        q.push_back(mk("idle_rest", GREEN, RED, 1'b0, 1'b0, 1'b0, 156));
        drain();
        $display("[TB] idle 200 cycles checked");

        // Stray expiry pulse while the timer is disabled
        mc_inject = 1'b1;
        q.push_back(mk("rest_inject", GREEN, RED, 1'b0, 1'b0, 1'b0, 1));
        drain();
        mc_inject = 1'b0;
        q.push_back(mk("rest_after_inject", GREEN, RED, 1'b0, 1'b0, 1'b0, 3));
        drain();
        $display("[TB] max_count in rest ignored");

        // Pedestrian request from rest: walk replaces the EW phase
        ped_req = 1'b1;
        q.push_back(mk("ped_req_cycle", GREEN, RED, 1'b0, 1'b0, 1'b0, 1));
        drain();
        ped_req = 1'b0;
        q.push_back(mk("rest_clear", GREEN, RED, 1'b0, 1'b0, 1'b1, 1));
        push_ew_round();
        push_walk_tail();
        q.push_back(mk("rest2", GREEN, RED, 1'b0, 1'b0, 1'b0, 5));
        drain();
        $display("[TB] ped request from rest cycle checked");

        // Requests at walk entry and during walk are dropped
        ped_req = 1'b1;
        q.push_back(mk("ped_req_cycle2", GREEN, RED, 1'b0, 1'b0, 1'b0, 1));
        drain();
        ped_req = 1'b0;
        q.push_back(mk("rest_clear2", GREEN, RED, 1'b0, 1'b0, 1'b1, 1));
        q.push_back(mk("ns_yellow", YELLOW, RED, 1'b0, 1'b1, 1'b0, 11));
        q.push_back(mk("all_red_a", RED, RED, 1'b0, 1'b1, 1'b0, 10));
        drain();
        ped_req = 1'b1;
        q.push_back(mk("all_red_a_last", RED, RED, 1'b0, 1'b1, 1'b0, 1));
        drain();
        ped_req = 1'b0;
        q.push_back(mk("ped_walk_a", RED, RED, 1'b1, 1'b1, 1'b0, 10));
        drain();
        ped_req = 1'b1;
        q.push_back(mk("ped_walk_req", RED, RED, 1'b1, 1'b1, 1'b0, 1));
        drain();
        ped_req = 1'b0;
        q.push_back(mk("ped_walk_b", RED, RED, 1'b1, 1'b1, 1'b0, 22));
        q.push_back(mk("all_red_b", RED, RED, 1'b0, 1'b1, 1'b0, 11));
        q.push_back(mk("ns_min_green", GREEN, RED, 1'b0, 1'b1, 1'b0, 44));
        q.push_back(mk("rest_no_rewalk", GREEN, RED, 1'b0, 1'b0, 1'b0, 10));
        drain();
        $display("[TB] ped requests in walk ignored");

        // Car from rest, pedestrian during EW green served next round
        ew_car = 1'b1;
        q.push_back(mk("car_clear", GREEN, RED, 1'b0, 1'b0, 1'b1, 1));
        push_ew_round();
        q.push_back(mk("ew_green_a", RED, GREEN, 1'b0, 1'b1, 1'b0, 20));
        drain();
        ped_req = 1'b1;
        ew_car  = 1'b0;
        q.push_back(mk("ew_green_req", RED, GREEN, 1'b0, 1'b1, 1'b0, 1));
        drain();
        ped_req = 1'b0;
        q.push_back(mk("ew_green_b", RED, GREEN, 1'b0, 1'b1, 1'b0, 23));
        q.push_back(mk("ew_yellow", RED, YELLOW, 1'b0, 1'b1, 1'b0, 11));
        q.push_back(mk("all_red_b", RED, RED, 1'b0, 1'b1, 1'b0, 11));
        q.push_back(mk("ns_green_busy", GREEN, RED, 1'b0, 1'b1, 1'b0, 44));
        push_ew_round();
        push_walk_tail();
        q.push_back(mk("rest3", GREEN, RED, 1'b0, 1'b0, 1'b0, 5));
        drain();
        $display("[TB] ped during EW green served next round");

        // Car present from reset, two full EW rounds, reset during EW yellow
        nrst   = 1'b0;
        ew_car = 1'b1;
        q.push_back(mk("in_reset2", GREEN, RED, 1'b0, 1'b1, 1'b0, 2));
        drain();
        nrst = 1'b1;
        q.push_back(mk("ns_green_car", GREEN, RED, 1'b0, 1'b1, 1'b0, 44));
        push_ew_round();
        q.push_back(mk("ew_green", RED, GREEN, 1'b0, 1'b1, 1'b0, 44));
        q.push_back(mk("ew_yellow", RED, YELLOW, 1'b0, 1'b1, 1'b0, 11));
        q.push_back(mk("all_red_b", RED, RED, 1'b0, 1'b1, 1'b0, 11));
        q.push_back(mk("ns_green_car2", GREEN, RED, 1'b0, 1'b1, 1'b0, 44));
        push_ew_round();
        q.push_back(mk("ew_green2_a", RED, GREEN, 1'b0, 1'b1, 1'b0, 10));
        drain();
        ped_req = 1'b1;
        q.push_back(mk("ew_green2_req", RED, GREEN, 1'b0, 1'b1, 1'b0, 1));
        drain();
        ped_req = 1'b0;
        ew_car  = 1'b0;
        q.push_back(mk("ew_green2_b", RED, GREEN, 1'b0, 1'b1, 1'b0, 33));
        q.push_back(mk("ew_yellow2", RED, YELLOW, 1'b0, 1'b1, 1'b0, 3));
        drain();
        #2;
        nrst = 1'b0;
        #1;
        check("async_reset_mid", {GREEN, RED, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        nrst = 1'b1;
        q.push_back(mk("post_reset_green", GREEN, RED, 1'b0, 1'b1, 1'b0, 44));
        q.push_back(mk("post_reset_rest", GREEN, RED, 1'b0, 1'b0, 1'b0, 10));
        drain();
        $display("[TB] reset during EW yellow cleared pending request");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
